// File: rtl/dffrs_seq_if.sv
// Request/status bundle between a controller and the dffrs reset/set sequencer.
interface dffrs_seq_if;
  logic init_req;  // force request, honoured only while the sequencer is idle
  logic init_val;  // force target: 1 = pulse S_out low, 0 = pulse R_out low
  logic R_out;     // active-low reset to the downstream dffrs bank
  logic S_out;     // active-low set to the downstream dffrs bank
  logic busy;      // reset or force sequence in progress
  logic done;      // one-cycle pulse when a sequence releases

  modport master (
    output init_req, init_val,
    input  R_out, S_out, busy, done
  );

  modport slave (
    input  init_req, init_val,
    output R_out, S_out, busy, done
  );
endinterface

// File: rtl/dffrs_seq.sv
// Reset/set sequencer for a bank of dffrs cells: asserts R_out asynchronously,
// releases it through a synchroniser plus a programmable hold, and serves
// force-to-0 / force-to-1 pulses. Every output is taken directly from a flop.
module dffrs_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic         clk,
  input  logic         R,
  dffrs_seq_if.slave   bus
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  localparam logic [2:0] ST_RST   = 3'd0;
  localparam logic [2:0] ST_SYNC  = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_IDLE  = 3'd3;
  localparam logic [2:0] ST_FORCE = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q,  sync_d;
  logic [CW-1:0]          cnt_q,   cnt_d;
  logic                   r_out_q, r_out_d;
  logic                   s_out_q, s_out_d;
  logic                   busy_q,  busy_d;
  logic                   done_q,  done_d;

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    state_d = state_q;
    sync_d  = sync_q;
    cnt_d   = cnt_q;
    r_out_d = r_out_q;
    s_out_d = s_out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_RST, ST_SYNC: begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
        // The chain becomes full on this edge: enter HOLD together with it.
        if (sync_q[SYNC_STAGES-2]) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          state_d = ST_SYNC;
        end
      end

      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          r_out_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_IDLE: begin
        if (bus.init_req) begin
          state_d = ST_FORCE;
          busy_d  = 1'b1;
          cnt_d   = HOLD_LOAD;
          // Only one of the two pins is ever pulled low.
          if (bus.init_val) s_out_d = 1'b0;
          else              r_out_d = 1'b0;
        end
      end

      ST_FORCE: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          r_out_d = 1'b1;
          s_out_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: state_d = ST_RST;
    endcase
  end

  // State and output flops; R low clears everything to the reset pattern at once.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q <= ST_RST;
      sync_q  <= '0;
      cnt_q   <= '0;
      r_out_q <= 1'b0;
      s_out_q <= 1'b1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      r_out_q <= r_out_d;
      s_out_q <= s_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.R_out = r_out_q;
  assign bus.S_out = s_out_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_dffrs_seq.sv
// Directed bench for dffrs_seq: default instance (2 sync stages, hold 4) and a
// swept instance (3 sync stages, hold 1), with a continuous R_out|S_out check.
module tb_dffrs_seq;

  logic clk;
  logic r_a;
  logic r_b;
  logic inv_en;
  int   n_checks;
  int   n_fail;

  dffrs_seq_if if_a ();
  dffrs_seq_if if_b ();

  dffrs_seq #(.SYNC_STAGES(2), .HOLD_CYCLES(4)) u_dut_a (
    .clk (clk),
    .R   (r_a),
    .bus (if_a.slave)
  );

  dffrs_seq #(.SYNC_STAGES(3), .HOLD_CYCLES(1)) u_dut_b (
    .clk (clk),
    .R   (r_b),
    .bus (if_b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outputs of instance A: R_out, S_out, busy, done.
  task automatic check_a(input string tag, input logic ro, input logic so,
                         input logic bz, input logic dn);
    check({tag, ".R_out"}, 32'(if_a.R_out), 32'(ro));
    check({tag, ".S_out"}, 32'(if_a.S_out), 32'(so));
    check({tag, ".busy"},  32'(if_a.busy),  32'(bz));
    check({tag, ".done"},  32'(if_a.done),  32'(dn));
  endtask

  task automatic check_b(input string tag, input logic ro, input logic so,
                         input logic bz, input logic dn);
    check({tag, ".R_out"}, 32'(if_b.R_out), 32'(ro));
    check({tag, ".S_out"}, 32'(if_b.S_out), 32'(so));
    check({tag, ".busy"},  32'(if_b.busy),  32'(bz));
    check({tag, ".done"},  32'(if_b.done),  32'(dn));
  endtask

  // Instance A release sequence counted from the first edge with R high:
  // R_out rises, busy falls and done pulses after edge 6; done drops after 7.
  // A set request is raised after edge req_at (0 = none) for one cycle.
  task automatic release_a(input string tag, input int req_at);
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == req_at + 1 && req_at != 0) if_a.init_req = 1'b0;
      check_a($sformatf("%s.e%0d", tag, i), (i >= 6), 1'b1, (i < 6), (i == 6));
      if (i == req_at) begin
        if_a.init_req = 1'b1;
        if_a.init_val = 1'b1;
      end
    end
  endtask

  // Downstream pins must never be low together.
  always @(negedge clk) begin
    if (inv_en) begin
      check("inv_a", 32'(if_a.R_out | if_a.S_out), 32'd1);
      check("inv_b", 32'(if_b.R_out | if_b.S_out), 32'd1);
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    inv_en   = 1'b0;
    if_a.init_req = 1'b0;
    if_a.init_val = 1'b0;
    if_b.init_req = 1'b0;
    if_b.init_val = 1'b0;
    r_a = 1'b1;
    r_b = 1'b1;
    #2;
    r_a = 1'b0;
    r_b = 1'b0;
    #1;
    inv_en = 1'b1;

    // Power-up: reset values while R is low.
    for (int i = 0; i < 3; i++) begin
      step();
      check_a("rst_a", 1'b0, 1'b1, 1'b1, 1'b0);
      check_b("rst_b", 1'b0, 1'b1, 1'b1, 1'b0);
    end
    r_a = 1'b1;
    release_a("pwr", 0);

    // Set force: S_out low exactly 4 cycles, done after e+4.
    if_a.init_req = 1'b1;
    if_a.init_val = 1'b1;
    step();
    if_a.init_req = 1'b0;
    check_a("set.acc", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check_a($sformatf("set.k%0d", k), 1'b1, (k == 4), (k < 4), (k == 4));
    end
    step();
    check_a("set.after", 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset force with request held: period 5, release on every fifth edge.
    if_a.init_req = 1'b1;
    if_a.init_val = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 12) if_a.init_req = 1'b0;
      check_a($sformatf("held.k%0d", k), (k % 5 == 0), 1'b1, (k % 5 != 0), (k % 5 == 0));
    end
    step();
    check_a("held.after", 1'b1, 1'b1, 1'b0, 1'b0);

    // Abort a set force two cycles in.
    if_a.init_req = 1'b1;
    if_a.init_val = 1'b1;
    step();
    if_a.init_req = 1'b0;
    check_a("abort.acc", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check_a("abort.mid", 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    r_a = 1'b0;
    #1;
    check_a("abort.async", 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    check_a("abort.rst", 1'b0, 1'b1, 1'b1, 1'b0);
    r_a = 1'b1;
    release_a("abort.rel", 0);

    // Glitch during SYNC re-times the release; a request in HOLD is dropped.
    r_a = 1'b0;
    step();
    r_a = 1'b1;
    step();
    check_a("glitch.sync", 1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    r_a = 1'b0;
    #3;
    r_a = 1'b1;
    release_a("glitch.rel", 3);
    for (int k = 1; k <= 3; k++) begin
      step();
      check_a($sformatf("ignore.k%0d", k), 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Swept instance: release after edge 4, one-cycle forces.
    r_b = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check_b($sformatf("swp.e%0d", i), (i >= 4), 1'b1, (i < 4), (i == 4));
    end
    if_b.init_req = 1'b1;
    if_b.init_val = 1'b0;
    step();
    if_b.init_req = 1'b0;
    check_b("swp.rf.acc", 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    check_b("swp.rf.rel", 1'b1, 1'b1, 1'b0, 1'b1);
    if_b.init_req = 1'b1;
    if_b.init_val = 1'b1;
    step();
    if_b.init_req = 1'b0;
    check_b("swp.sf.acc", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check_b("swp.sf.rel", 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    check_b("swp.idle", 1'b1, 1'b1, 1'b0, 1'b0);

    inv_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
